send_frame_backoff_ctrl: RTL and testbench

CSMA/CA random-backoff controller for the send_frame transmit path. It draws a pseudo-random slot count and drives it, with the slot duration, into the existing 17x17→32 unsigned multiplier `send_frame_mul_mucud`. It then consumes the 32-bit product as a tick budget, counting it down while the channel is idle. It signals `done` when transmission may start, or `fail` when retries are exhausted.

---
 rtl/mac_backoff_pkg.sv | 30 +++
 rtl/backoff_lfsr.sv | 26 ++
 rtl/send_frame_mul_mucud.sv | 11 +
 rtl/send_frame_backoff_ctrl.sv | 136 +++++++++++++
 tb/tb_send_frame_backoff_ctrl.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/mac_backoff_pkg.sv
// Shared types and constants for the send_frame CSMA/CA backoff controller.
// Holds the FSM encoding, LFSR tap mask and datapath widths.
package mac_backoff_pkg;

    localparam int LFSR_W = 17;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 17'h12000;
    localparam int BE_W = 3;
    localparam int REM_W = 32;
    localparam int NB_W = 4;
    localparam int SLOT_W = 5;
    localparam int OP_W = 17;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAW,
        S_MUL,
        S_COUNT,
        S_DONE,
        S_FAIL
    } state_t;

    // Top e bits of the LFSR word, right-aligned.
    function automatic logic [SLOT_W-1:0] draw_slots(
        input logic [LFSR_W-1:0] v,
        input logic [BE_W-1:0]   e
    );
        return SLOT_W'(v >> (LFSR_W - int'(e)));
    endfunction

endpackage

// File: rtl/backoff_lfsr.sv
// 17-bit Galois LFSR (x^17 + x^14 + 1) that steps only when advance is high.
// Exposes the upcoming value so the draw can use it in the stepping cycle.
module backoff_lfsr
    import mac_backoff_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 17'h00001
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              advance,
    output logic [LFSR_W-1:0] nxt
);

    logic [LFSR_W-1:0] value;

    assign nxt = (value >> 1) ^ (value[0] ? LFSR_TAPS : '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= SEED;
        end else if (advance) begin
            value <= nxt;
        end
    end

endmodule

// File: rtl/send_frame_mul_mucud.sv
// Combinational 17x17 unsigned multiplier feeding the backoff tick budget.
// Operands are bounded upstream so the product fits in 32 bits.
module send_frame_mul_mucud (
    input  logic [16:0] din0,
    input  logic [16:0] din1,
    output logic [31:0] dout
);

    assign dout = {15'b0, din0} * {15'b0, din1};

endmodule

// File: rtl/send_frame_backoff_ctrl.sv
// CSMA/CA random-backoff controller: draws a slot count, scales it by the
// slot duration through an external multiplier and counts down idle ticks.
module send_frame_backoff_ctrl
    import mac_backoff_pkg::*;
#(
    parameter int unsigned       MIN_BE      = 3,
    parameter int unsigned       MAX_BE      = 5,
    parameter int unsigned       MAX_RETRIES = 4,
    parameter logic [LFSR_W-1:0] LFSR_SEED   = 17'h00001
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic              start,
    input  logic              retry,
    input  logic              abort,
    input  logic              chan_busy,
    input  logic [OP_W-1:0]   slot_ticks,
    output logic [OP_W-1:0]   mul_a,
    output logic [OP_W-1:0]   mul_b,
    input  logic [REM_W-1:0]  mul_p,
    output logic              start_ready,
    output logic              done,
    output logic              fail,
    output logic [REM_W-1:0]  remaining,
    output logic [BE_W-1:0]   be
);

    localparam logic [BE_W-1:0] MIN_BE_L = BE_W'(MIN_BE);
    localparam logic [BE_W-1:0] MAX_BE_L = BE_W'(MAX_BE);
    localparam logic [NB_W-1:0] MAX_NB   = NB_W'(MAX_RETRIES);

    state_t            state;
    state_t            state_n;
    logic              accept;
    logic              to_fail;
    logic              lfsr_adv;
    logic [LFSR_W-1:0] lfsr_nxt;
    logic [NB_W-1:0]   nb;
    logic              rem_zero;

    assign rem_zero = (remaining == '0);
    assign to_fail  = retry && (nb == MAX_NB);

    backoff_lfsr #(
        .SEED(LFSR_SEED)
    ) u_lfsr (
        .clk    (ap_clk),
        .rst    (ap_rst),
        .advance(lfsr_adv),
        .nxt    (lfsr_nxt)
    );

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        accept   = 1'b0;
        lfsr_adv = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_n = to_fail ? S_FAIL : S_DRAW;
                end
            end
            S_DRAW: begin
                lfsr_adv = 1'b1;
                state_n  = S_MUL;
            end
            S_MUL: begin
                state_n = S_COUNT;
            end
            S_COUNT: begin
                if (rem_zero) begin
                    state_n = S_DONE;
                end
            end
            S_DONE, S_FAIL: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
        // Abort wins over everything and must not disturb nb/be/LFSR.
        if (abort) begin
            state_n  = S_IDLE;
            accept   = 1'b0;
            lfsr_adv = 1'b0;
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            nb        <= '0;
            be        <= MIN_BE_L;
            mul_a     <= '0;
            mul_b     <= '0;
            remaining <= '0;
        end else if (!abort) begin
            if (accept) begin
                if (!retry || to_fail) begin
                    nb <= '0;
                    be <= MIN_BE_L;
                end else begin
                    nb <= nb + NB_W'(1);
                    be <= (be < MAX_BE_L) ? be + BE_W'(1) : MAX_BE_L;
                end
                if (!to_fail) begin
                    mul_b <= slot_ticks;
                end
            end
            if (state == S_DRAW) begin
                mul_a <= {{(OP_W-SLOT_W){1'b0}}, draw_slots(lfsr_nxt, be)};
            end
            if (state == S_MUL) begin
                remaining <= mul_p;
            end
            // Busy only pauses the countdown; the budget is kept.
            if (state == S_COUNT && !rem_zero && !chan_busy) begin
                remaining <= remaining - REM_W'(1);
            end
        end
    end

    assign start_ready = (state == S_IDLE);
    assign done        = (state == S_DONE);
    assign fail        = (state == S_FAIL);

endmodule

// File: tb/tb_send_frame_backoff_ctrl.sv
// Randomized bench for send_frame_backoff_ctrl against a transaction-level
// model of the backoff rules (slot draw, retry/BE policy, idle-tick countdown).
module tb_send_frame_backoff_ctrl;

    localparam int MIN_BE = 3;
    localparam int MAX_BE = 5;
    localparam int MAX_RETRIES = 4;
    localparam logic [16:0] SEED = 17'h00001;

    logic        ap_clk = 1'b0;
    logic        ap_rst = 1'b1;
    logic        start = 1'b0;
    logic        retry = 1'b0;
    logic        abort = 1'b0;
    logic        chan_busy = 1'b0;
    logic [16:0] slot_ticks = '0;
    logic [16:0] mul_a;
    logic [16:0] mul_b;
    logic [31:0] mul_p;
    logic        start_ready;
    logic        done;
    logic        fail;
    logic [31:0] remaining;
    logic [2:0]  be;

    int n_cmp = 0;
    int n_bad = 0;

    int          m_nb;
    int          m_be;
    logic [16:0] m_lfsr;

    always #5 ap_clk = ~ap_clk;

    send_frame_backoff_ctrl #(
        .MIN_BE     (MIN_BE),
        .MAX_BE     (MAX_BE),
        .MAX_RETRIES(MAX_RETRIES),
        .LFSR_SEED  (SEED)
    ) dut (
        .ap_clk     (ap_clk),
        .ap_rst     (ap_rst),
        .start      (start),
        .retry      (retry),
        .abort      (abort),
        .chan_busy  (chan_busy),
        .slot_ticks (slot_ticks),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_p      (mul_p),
        .start_ready(start_ready),
        .done       (done),
        .fail       (fail),
        .remaining  (remaining),
        .be         (be)
    );

    send_frame_mul_mucud u_mul (
        .din0(mul_a),
        .din1(mul_b),
        .dout(mul_p)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic model_reset();
        m_nb = 0;
        m_be = MIN_BE;
        m_lfsr = SEED;
    endtask

    function automatic logic [16:0] lfsr_step(input logic [16:0] s);
        return s[0] ? ((s >> 1) ^ 17'h12000) : (s >> 1);
    endfunction

    function automatic int slots_of(input logic [16:0] s, input int e);
        return int'(s) / (1 << (17 - e));
    endfunction

    // stop_kind: 0 none, 1 abort, 2 async reset, at count cycle stop_at.
    // bmode: 0 idle channel, 1 random busy, 2 busy for 7 cycles from k=2.
    task automatic do_op(input bit rt, input int ticks, input int bmode,
                         input int stop_at, input int stop_kind,
                         input bit poke);
        int p;
        int r;
        int k;
        int sl;
        bit bz;
        bit failp;
        failp = rt && (m_nb == MAX_RETRIES);
        if (!rt || failp) begin
            m_nb = 0;
            m_be = MIN_BE;
        end else begin
            m_nb++;
            m_be = (m_be + 1 > MAX_BE) ? MAX_BE : m_be + 1;
        end
        retry = rt;
        slot_ticks = 17'(ticks);
        start = 1'b1;
        tick();
        start = 1'b0;
        retry = 1'($urandom_range(0, 1));
        slot_ticks = 17'($urandom);
        if (failp) begin
            chk("fail_pulse", 32'(fail), 32'd1);
            chk("fail_nodone", 32'(done), 32'd0);
            chk("fail_rdy", 32'(start_ready), 32'd0);
            chk("fail_be", 32'(be), 32'(m_be));
            tick();
            chk("fail_clear", 32'(fail), 32'd0);
            chk("fail_idle", 32'(start_ready), 32'd1);
            return;
        end
        chk("draw_rdy", 32'(start_ready), 32'd0);
        chk("draw_be", 32'(be), 32'(m_be));
        chk("draw_fail", 32'(fail), 32'd0);
        m_lfsr = lfsr_step(m_lfsr);
        sl = slots_of(m_lfsr, m_be);
        p = sl * ticks;
        tick();
        chk("mul_a", 32'(mul_a), 32'(sl));
        chk("mul_b", 32'(mul_b), 32'(ticks));
        tick();
        chk("rem_load", remaining, 32'(p));
        r = p;
        k = 0;
        while (r != 0) begin
            case (bmode)
                0: bz = 1'b0;
                1: bz = ($urandom_range(0, 3) == 0);
                default: bz = (k >= 2 && k < 9);
            endcase
            chan_busy = bz;
            start = poke && (k == 1);
            if (stop_at == k && stop_kind == 1) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
                chan_busy = 1'b0;
                start = 1'b0;
                chk("abort_rdy", 32'(start_ready), 32'd1);
                chk("abort_nodone", 32'(done), 32'd0);
                tick();
                chk("abort_quiet", 32'(done), 32'd0);
                return;
            end
            if (stop_at == k && stop_kind == 2) begin
                ap_rst = 1'b1;
                #1;
                chk("arst_rem", remaining, 32'd0);
                chk("arst_rdy", 32'(start_ready), 32'd1);
                chk("arst_be", 32'(be), 32'(MIN_BE));
                chk("arst_mula", 32'(mul_a), 32'd0);
                tick();
                ap_rst = 1'b0;
                chan_busy = 1'b0;
                start = 1'b0;
                model_reset();
                return;
            end
            tick();
            k++;
            if (!bz) r--;
            chk("count_rem", remaining, 32'(r));
            chk("count_nodone", 32'(done), 32'd0);
            chk("count_rdy", 32'(start_ready), 32'd0);
        end
        chan_busy = 1'($urandom_range(0, 1));
        start = 1'b0;
        tick();
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_nofail", 32'(fail), 32'd0);
        chan_busy = 1'b0;
        tick();
        chk("done_clear", 32'(done), 32'd0);
        chk("done_idle", 32'(start_ready), 32'd1);
    endtask

    initial begin
        int v;
        int kind;
        model_reset();
        ap_rst = 1'b1;
        repeat (2) @(posedge ap_clk);
        #1;
        chk("rst_rdy", 32'(start_ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_fail", 32'(fail), 32'd0);
        chk("rst_rem", remaining, 32'd0);
        chk("rst_be", 32'(be), 32'(MIN_BE));
        chk("rst_mula", 32'(mul_a), 32'd0);
        chk("rst_mulb", 32'(mul_b), 32'd0);
        ap_rst = 1'b0;
        tick();
        chk("post_rst_rdy", 32'(start_ready), 32'd1);

        do_op(1'b0, 10, 0, -1, 0, 1'b0);
        do_op(1'b1, 5, 2, -1, 0, 1'b0);

        do_op(1'b0, 3, 1, -1, 0, 1'b0);
        repeat (4) do_op(1'b1, 3, 1, -1, 0, 1'b0);
        do_op(1'b1, 3, 1, -1, 0, 1'b0);
        chk("after_fail_be", 32'(be), 32'(MIN_BE));

        do_op(1'b0, 0, 1, -1, 0, 1'b0);
        do_op(1'b0, 6, 0, 2, 1, 1'b0);
        do_op(1'b1, 8, 0, 3, 2, 1'b0);
        do_op(1'b0, 10, 0, -1, 0, 1'b0);
        do_op(1'b0, 4, 1, -1, 0, 1'b1);

        repeat (40) begin
            v = $urandom_range(0, 9);
            kind = (v == 0) ? 1 : (v == 1) ? 2 : 0;
            do_op($urandom_range(0, 3) != 0, $urandom_range(0, 12), 1,
                  $urandom_range(0, 10), kind, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
